// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide sequencer.
package ex_muldiv_sequencer_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_CYCLES = 3;
    localparam int unsigned CNT_W      = $clog2(XLEN);

    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(XLEN - 1);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [6:0] M_FUNCT7  = 7'b0000001;
    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage <-> M-extension sequencer handshake.
interface ex_muldiv_sequencer_if;
    import ex_muldiv_sequencer_pkg::*;

    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall_ex;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  stall_ex, busy, result_valid, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output stall_ex, busy, result_valid, result
    );

endinterface

// File: rtl/ex_muldiv_sequencer_div_step.sv
// One restoring division iteration on unsigned magnitudes.
module ex_muldiv_sequencer_div_step
    import ex_muldiv_sequencer_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic          w_fits;

    // Shift rem:quo left by one, trial-subtract, keep difference when non-negative.
    always_comb begin
        w_shift = {i_rem, i_quo[XLEN-1]};
        w_diff  = w_shift - {1'b0, i_divisor};
        w_fits  = ~w_diff[XLEN];
        o_rem   = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        o_quo   = {i_quo[XLEN-2:0], w_fits};
    end

endmodule

// File: rtl/ex_muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: fixed-latency multiply, iterative radix-2 divide,
// pipeline hold via stall_ex until the result is ready.
module ex_muldiv_sequencer
    import ex_muldiv_sequencer_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    ex_muldiv_sequencer_if.slave bus
);

    muldiv_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_f3;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_divisor;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_busy;
    logic             r_valid;
    logic [XLEN-1:0]  r_result;

    logic             w_in_signed;
    logic             w_overflow;
    logic [XLEN-1:0]  w_a_mag;
    logic [XLEN-1:0]  w_b_mag;
    logic [XLEN-1:0]  w_rem_nxt;
    logic [XLEN-1:0]  w_quo_nxt;
    logic [XLEN-1:0]  w_div_res;
    logic [XLEN:0]    w_a_ext;
    logic [XLEN:0]    w_b_ext;
    logic [2*XLEN-1:0] w_a_wide;
    logic [2*XLEN-1:0] w_b_wide;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]  w_mul_res;

    // Operand decode at issue: signed DIV/REM use magnitudes, INT_MIN/-1 short-cuts.
    always_comb begin
        w_in_signed = bus.funct3[2] & ~bus.funct3[0];
        w_overflow  = w_in_signed && (bus.op_a == SMIN) && (&bus.op_b);
        w_a_mag     = (w_in_signed && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
        w_b_mag     = (w_in_signed && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;
    end

    ex_muldiv_sequencer_div_step u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    // Sign fix applied to the final division step output.
    always_comb begin
        if (r_f3[1]) w_div_res = r_neg_r ? -w_rem_nxt : w_rem_nxt;
        else         w_div_res = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    end

    // Behavioural product on 33-bit sign/zero-extended operands; low 2*XLEN bits suffice.
    always_comb begin
        w_a_ext   = {(r_f3[0] ^ r_f3[1]) & r_a[XLEN-1], r_a};
        w_b_ext   = {(r_f3 == MULH_F3[1:0]) & r_b[XLEN-1], r_b};
        w_a_wide  = {{(XLEN-1){w_a_ext[XLEN]}}, w_a_ext};
        w_b_wide  = {{(XLEN-1){w_b_ext[XLEN]}}, w_b_ext};
        w_prod    = w_a_wide * w_b_wide;
        w_mul_res = (r_f3 == MUL_F3[1:0]) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    // Sequencer state machine with registered busy/result_valid/result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_f3      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_result  <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        r_f3      <= bus.funct3[1:0];
                        r_a       <= bus.op_a;
                        r_b       <= bus.op_b;
                        r_rem     <= '0;
                        r_quo     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_neg_q   <= w_in_signed & (bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1]);
                        r_neg_r   <= w_in_signed & bus.op_a[XLEN-1];
                        if (!bus.funct3[2]) begin
                            r_state <= S_MUL;
                            r_cnt   <= MUL_CNT_INIT;
                            r_busy  <= 1'b1;
                        end else if (bus.op_b == '0) begin
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= bus.funct3[1] ? bus.op_a : '1;
                        end else if (w_overflow) begin
                            r_state  <= S_DONE;
                            r_valid  <= 1'b1;
                            r_result <= bus.funct3[1] ? '0 : bus.op_a;
                        end else begin
                            r_state <= S_DIV;
                            r_cnt   <= DIV_CNT_INIT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state  <= S_DONE;
                        r_busy   <= 1'b0;
                        r_valid  <= 1'b1;
                        r_result <= w_mul_res;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DIV: begin
                    if (bus.flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        if (r_cnt == '0) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_valid  <= 1'b1;
                            r_result <= w_div_res;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Hold upstream while an op is being accepted or in flight; released in S_DONE.
    assign bus.stall_ex     = (bus.start & (r_state == S_IDLE) & ~bus.flush) | r_busy;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_valid;
    assign bus.result       = r_result;

endmodule
